pe_idx_buf: RTL and testbench
=============================

# pe_idx_buf

Per-PE double-buffered index store that sits directly downstream of the DDR-to-index-buffer loader. It captures that stage's broadcast write stream (data/address plus this PE's bit of the write-enable mask) into the current write bank. It then replays a completed bank to the PE compute pipeline as a valid/ready stream of packed index pairs. Two banks let the next layer's indices load while the current ones are consumed.

## Interface
- IDX_W, 8, width of one index; a stored entry is an index pair, 2*IDX_W bits
- DEPTH, 256, entries per bank
- ADDR_W, bw(DEPTH), entry address width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- wr_data  in  2*IDX_W  entry from loader
- wr_addr  in  ADDR_W  entry address
- wr_en  in  1  this PE's write-enable bit
- wr_done  in  1  pulse: current write bank complete
- wr_bank_ready  out  1  current write bank is free
- rd_start  in  1  pulse: begin a replay pass
- rd_num  in  ADDR_W+1  entries to replay, 0..DEPTH
- rd_keep  in  1  sampled with rd_start; 1 = keep bank after pass
- rd_start_ready  out  1  read side idle and a full bank exists
- idx_data  out  2*IDX_W  replayed entry
- idx_valid  out  1  idx_data valid
- idx_ready  in  1  consumer accepts
- rd_done  out  1  one-cycle pulse: pass finished
- ovf_err  out  1  sticky: wr_done dropped because the bank was full

## Operation
- State: wr_bank, rd_bank (1 bit each), full[1:0], and a read FSM with states IDLE, RUN, DONE.
- Write: when wr_en=1 and wr_bank_ready=1, RAM[wr_bank][wr_addr] <= wr_data. When wr_en=1 and wr_bank_ready=0, the write is dropped.
- wr_bank_ready = !full[wr_bank].
- wr_done with wr_bank_ready=1: full[wr_bank] <= 1 and wr_bank toggles. With wr_bank_ready=0: ignored, ovf_err <= 1.
- rd_start_ready = (FSM==IDLE) && full[rd_bank]. A rd_start while rd_start_ready=0 is ignored.
- On accepted rd_start: latch rd_num and rd_keep; clear the read and output counters.
  - rd_num=0: go to DONE.
  - Otherwise: go to RUN.
- RUN, issue side: issue one RAM read (addr = read counter) per cycle while issued < rd_num and (skid occupancy + in-flight) < 2.
- RUN, output side: a 2-entry skid FIFO holds RAM outputs. Zero bubbles when idx_ready=1; no loss under any idx_ready pattern.
- RUN -> DONE on the handshake (idx_valid && idx_ready) of entry rd_num-1.
- DONE, for one cycle:
  - rd_done=1.
  - If the latched keep=0: full[rd_bank] <= 0 and rd_bank toggles.
  - Return to IDLE.
- Same-cycle events: wr_done is evaluated against pre-update full bits. The release clears a bank other than a writable one, so no conflict can arise.
- Counters are ADDR_W+1 wide; rd_num=DEPTH replays addresses 0..DEPTH-1 with no wrap.
- rst at any time:
  - full=0, banks=0, FSM=IDLE, skid flushed.
  - Outputs: idx_valid=0, rd_done=0, ovf_err=0, wr_bank_ready=1, rd_start_ready=0, idx_data=0.
  - RAM contents are not cleared.

## Timing
- Write to RAM: 1 cycle. wr_done at edge T makes rd_start_ready=1 at T+1 if the read side is idle on that bank.
- rd_start accepted at edge T:
  - First RAM read at T+1.
  - idx_valid=1 from T+2.
  - rd_start_ready=0 from T+1 until rd_done deasserts.
- With idx_ready held 1: N entries on N consecutive cycles T+2..T+N+1, then rd_done at T+N+2. Bank release is visible at T+N+3.
- rd_num=0: rd_done at T+1, no idx_valid.
- idx_data/idx_valid hold stable while idx_valid && !idx_ready.
- rd_done lasts exactly one cycle per accepted rd_start.

## Test plan
- Fill bank 0 with addr a -> data 16'hA000+a for a=0..15, then wr_done, then rd_start with rd_num=16, keep=0, idx_ready=1 -> 16 entries A000..A00F on consecutive cycles starting 2 cycles after start; rd_done once; bank 0 freed.
- Same fill, idx_ready toggling 1,0,0,1 randomly -> exact in-order sequence with no drops or duplicates; data stable while stalled.
- Fill both banks (B000.., C000..), third wr_done -> ovf_err=1 and wr_bank_ready=0. Pass bank 0 with keep=1 twice -> B-data twice. Then keep=0 -> bank 1 C-data is next.
- rd_num=256 on a full bank -> addresses 0..255 replayed; rd_done after the 256th handshake.
- rd_num=0 -> rd_done at T+1, idx_valid never high. rd_start while idle with no full bank -> ignored.
- rst asserted mid-RUN after 5 handshakes -> next cycle idx_valid=0, full=0, wr_bank_ready=1; a new fill and replay works normally.

Source files
------------

// File: rtl/pe_idx_buf.sv
//------------------------------------------------------------------------------
// Module      : pe_idx_buf
// Description : Per-PE double-buffered index store. Captures the loader's
//               broadcast write stream into the current write bank and
//               replays a completed bank as a valid/ready stream of index
//               pairs through a 2-entry skid FIFO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_idx_buf #(
   parameter int IDX_W  = 8,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*IDX_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic                 wr_en,
   input  logic                 wr_done,
   output logic                 wr_bank_ready,
   input  logic                 rd_start,
   input  logic [ADDR_W:0]      rd_num,
   input  logic                 rd_keep,
   output logic                 rd_start_ready,
   output logic [2*IDX_W-1:0]   idx_data,
   output logic                 idx_valid,
   input  logic                 idx_ready,
   output logic                 rd_done,
   output logic                 ovf_err
);

   localparam int DW = 2 * IDX_W;
   localparam int CW = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;

   // Both banks live in one array; the bank bit is the address MSB.
   logic [DW-1:0]     mem [0:2*DEPTH-1];

   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        full;
   logic              ovf;

   logic [CW-1:0]     num;
   logic              keep;
   logic [CW-1:0]     iss_cnt;
   logic [CW-1:0]     out_cnt;

   logic [DW-1:0]     ram_q;
   logic              inflight;
   logic [DW-1:0]     skid0;
   logic [DW-1:0]     skid1;
   logic [1:0]        occ;

   logic              wr_ok;
   logic              start_ok;
   logic              issue;
   logic              pop;
   logic              last_pop;

   assign wr_ok     = !full[wr_bank];
   assign start_ok  = (state == S_IDLE) && full[rd_bank];
   // A read is only issued when its result is guaranteed a skid slot.
   assign issue     = (state == S_RUN) && (iss_cnt < num) &&
                      (({1'b0, inflight} + occ) < 2'd2);
   assign pop       = idx_valid && idx_ready;
   assign last_pop  = pop && (out_cnt == (num - CW'(1)));

   // Skid head has priority; when empty the RAM output is forwarded directly.
   assign idx_valid      = inflight || (occ != 2'd0);
   assign idx_data       = (occ != 2'd0) ? skid0 : (inflight ? ram_q : '0);
   assign wr_bank_ready  = wr_ok;
   assign rd_start_ready = start_ok;
   assign rd_done        = (state == S_DONE);
   assign ovf_err        = ovf;

   // Loader writes land in the current write bank only while it is free.
   always_ff @(posedge clk) begin
      if (wr_en && wr_ok) begin
         mem[{wr_bank, wr_addr}] <= wr_data;
      end
   end

   // Synchronous RAM read for the replay stream.
   always_ff @(posedge clk) begin
      if (issue) begin
         ram_q <= mem[{rd_bank, iss_cnt[ADDR_W-1:0]}];
      end
   end

   // Bank ownership: completion marks a bank full, a non-keep pass frees it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= 2'b00;
         ovf     <= 1'b0;
      end else begin
         if (wr_done) begin
            if (wr_ok) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end else begin
               ovf <= 1'b1;
            end
         end
         if ((state == S_DONE) && !keep) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   // Replay sequencer: counts issued reads and accepted outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         num     <= '0;
         keep    <= 1'b0;
         iss_cnt <= '0;
         out_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rd_start && start_ok) begin
                  num     <= rd_num;
                  keep    <= rd_keep;
                  iss_cnt <= '0;
                  out_cnt <= '0;
                  state   <= (rd_num == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (issue) begin
                  iss_cnt <= iss_cnt + CW'(1);
               end
               if (pop) begin
                  out_cnt <= out_cnt + CW'(1);
               end
               if (last_pop) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Skid FIFO: parks RAM results the consumer did not take directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         skid0    <= '0;
         skid1    <= '0;
      end else begin
         inflight <= issue;
         case (occ)
            2'd0: begin
               if (inflight && !pop) begin
                  skid0 <= ram_q;
                  occ   <= 2'd1;
               end
            end
            2'd1: begin
               if (pop) begin
                  if (inflight) begin
                     skid0 <= ram_q;
                  end else begin
                     occ <= 2'd0;
                  end
               end else if (inflight) begin
                  skid1 <= ram_q;
                  occ   <= 2'd2;
               end
            end
            2'd2: begin
               if (pop) begin
                  skid0 <= skid1;
                  if (inflight) begin
                     skid1 <= ram_q;
                  end else begin
                     occ <= 2'd1;
                  end
               end
            end
            default: begin
               occ <= 2'd0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pe_idx_buf.sv
//------------------------------------------------------------------------------
// Module      : tb_pe_idx_buf
// Description : Scoreboard bench for pe_idx_buf with a bank-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_idx_buf;

   localparam int IDX_W  = 8;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam int DW     = 2 * IDX_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     wr_data;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_en;
   logic              wr_done;
   logic              wr_bank_ready;
   logic              rd_start;
   logic [ADDR_W:0]   rd_num;
   logic              rd_keep;
   logic              rd_start_ready;
   logic [DW-1:0]     idx_data;
   logic              idx_valid;
   logic              idx_ready;
   logic              rd_done;
   logic              ovf_err;

   pe_idx_buf #(.IDX_W(IDX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .wr_done(wr_done),
      .wr_bank_ready(wr_bank_ready),
      .rd_start(rd_start), .rd_num(rd_num), .rd_keep(rd_keep),
      .rd_start_ready(rd_start_ready),
      .idx_data(idx_data), .idx_valid(idx_valid), .idx_ready(idx_ready),
      .rd_done(rd_done), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            hs_count = 0;
   bit            rand_ready = 1'b0;
   logic [DW-1:0] exp_q[$];

   // Reference model: bank contents, which banks hold complete data,
   // which bank is being written and which is replayed next.
   logic [DW-1:0] m_mem [2][DEPTH];
   bit            m_full [2];
   int            m_wb = 0;
   int            m_rb = 0;
   bit            m_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Consumer ready: constant 1 or random per cycle.
   initial begin
      idx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         idx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each handshake, checks stall stability.
   initial begin
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (prev_stall) begin
            check("stall_valid", 32'(idx_valid), 32'd1);
            check("stall_data", 32'(idx_data), 32'(prev_data));
         end
         if (idx_valid && idx_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_entry: got %0h expected none", idx_data);
            end else begin
               e = exp_q.pop_front();
               check("entry", 32'(idx_data), 32'(e));
            end
         end
         prev_stall = idx_valid && !idx_ready && !rst;
         prev_data  = idx_data;
      end
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic write_entry(input int addr, input logic [DW-1:0] data);
      wr_en   = 1'b1;
      wr_addr = addr[ADDR_W-1:0];
      wr_data = data;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (!m_full[m_wb]) m_mem[m_wb][addr] = data;
   endtask

   task automatic mark_done();
      wr_done = 1'b1;
      @(posedge clk);
      #1;
      wr_done = 1'b0;
      if (!m_full[m_wb]) begin
         m_full[m_wb] = 1'b1;
         m_wb ^= 1;
      end else begin
         m_ovf = 1'b1;
      end
      check("wr_bank_ready", 32'(wr_bank_ready), 32'(!m_full[m_wb]));
      check("ovf_err", 32'(ovf_err), 32'(m_ovf));
   endtask

   task automatic fill(input int n, input logic [DW-1:0] base, input bit rnd);
      for (int a = 0; a < n; a++) write_entry(a, rnd ? DW'($urandom) : base + DW'(a));
      mark_done();
   endtask

   // One replay pass; timed=1 also checks exact cycle positions (ready held 1).
   task automatic do_pass(input int num, input bit keep, input bit timed);
      int k, first_v, done_at, done_cnt, vcnt, budget;
      check("start_ready", 32'(rd_start_ready), 32'(m_full[m_rb]));
      for (int i = 0; i < num; i++) exp_q.push_back(m_mem[m_rb][i]);
      rd_start = 1'b1;
      rd_num   = (ADDR_W+1)'(num);
      rd_keep  = keep;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      rd_num   = (ADDR_W+1)'($urandom_range(0, 511));
      rd_keep  = 1'($urandom_range(0, 1));
      k = 0; first_v = -1; done_at = -1; done_cnt = 0; vcnt = 0;
      budget = num * 40 + 50;
      while (k <= budget && !(done_at >= 0 && k > done_at + 1)) begin
         @(negedge clk);
         if (idx_valid) begin
            vcnt++;
            if (first_v < 0) first_v = k;
         end
         if (rd_done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         k++;
      end
      check("rd_done_pulses", 32'(done_cnt), 32'd1);
      if (timed) begin
         check("first_valid", 32'(first_v), (num > 0) ? 32'd1 : 32'hFFFF_FFFF);
         check("done_at", 32'(done_at), (num > 0) ? 32'(num + 1) : 32'd0);
         check("valid_cycles", 32'(vcnt), 32'(num));
      end
      if (!keep) begin
         m_full[m_rb] = 1'b0;
         m_rb ^= 1;
      end
      check("start_ready_after", 32'(rd_start_ready), 32'(m_full[m_rb]));
      check("q_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base, k, cnt;
      rst = 1'b1; wr_data = '0; wr_addr = '0; wr_en = 1'b0; wr_done = 1'b0;
      rd_start = 1'b0; rd_num = '0; rd_keep = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_idx_valid", 32'(idx_valid), 32'd0);
      check("rst_rd_done", 32'(rd_done), 32'd0);
      check("rst_ovf_err", 32'(ovf_err), 32'd0);
      check("rst_wr_bank_ready", 32'(wr_bank_ready), 32'd1);
      check("rst_rd_start_ready", 32'(rd_start_ready), 32'd0);
      check("rst_idx_data", 32'(idx_data), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic fill and timed replay with ready held high.
      fill(16, 16'hA000, 1'b0);
      do_pass(16, 1'b0, 1'b1);

      // Same fill, random backpressure.
      rand_ready = 1'b1;
      fill(16, 16'hA000, 1'b0);
      do_pass(16, 1'b0, 1'b0);

      // Both banks full, overflow, dropped write, keep passes.
      fill(16, 16'hB000, 1'b0);
      fill(16, 16'hC000, 1'b0);
      mark_done();
      write_entry(3, 16'hDEAD);
      check("full_wr_bank_ready", 32'(wr_bank_ready), 32'd0);
      do_pass(16, 1'b1, 1'b0);
      do_pass(16, 1'b1, 1'b0);
      do_pass(16, 1'b0, 1'b0);
      do_pass(16, 1'b0, 1'b0);

      // Whole-bank replay.
      rand_ready = 1'b0;
      fill(DEPTH, '0, 1'b1);
      do_pass(DEPTH, 1'b0, 1'b1);

      // Zero-length pass, then a start with no full bank.
      fill(4, 16'h5000, 1'b0);
      do_pass(0, 1'b0, 1'b1);
      check("idle_empty_ready", 32'(rd_start_ready), 32'(m_full[m_rb]));
      rd_start = 1'b1; rd_num = 9'd4; rd_keep = 1'b0;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (idx_valid || rd_done) cnt++;
      end
      check("ignored_start", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a pass.
      fill(16, 16'hD000, 1'b0);
      for (int i = 0; i < 16; i++) exp_q.push_back(m_mem[m_rb][i]);
      rd_start = 1'b1; rd_num = 9'd16; rd_keep = 1'b0;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      base = hs_count;
      k = 0;
      while (hs_count < base + 5 && k < 100) begin
         @(posedge clk);
         k++;
      end
      check("hs_before_rst", 32'(hs_count - base), 32'd5);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_idx_valid", 32'(idx_valid), 32'd0);
      check("mid_rst_wr_bank_ready", 32'(wr_bank_ready), 32'd1);
      check("mid_rst_rd_start_ready", 32'(rd_start_ready), 32'd0);
      check("mid_rst_ovf_err", 32'(ovf_err), 32'd0);
      check("mid_rst_idx_data", 32'(idx_data), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_full[0] = 1'b0; m_full[1] = 1'b0; m_wb = 0; m_rb = 0; m_ovf = 1'b0;
      rand_ready = 1'b1;
      fill(8, 16'hE000, 1'b0);
      do_pass(8, 1'b0, 1'b0);

      check("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
